bg_loader_dma: RTL

Parametrised background copy engine: on a start request it streams one selected background image, word by word, from external SRAM into the on-chip framebuffer (OCM). It generalises the earlier single-size background loader with configurable image size, background count, data width and stride. It adds an explicit word counter, a start/busy/done handshake, wait-state-tolerant handshakes on both the SRAM and OCM sides, abort, and a bad-select error. It sits between the game-state controller (start, select) and the SRAM controller / OCM framebuffer write port.

---
 rtl/bg_loader_pkg.sv | 26 ++
 rtl/bg_loader_dma_bg_addr_gen.sv | 50 +++++
 rtl/bg_loader_dma.sv | 109 ++++++++++
 3 files changed

// File: rtl/bg_loader_pkg.sv
// Shared types and default geometry for the background loader DMA.
package bg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_IMG_W     = 640;
   localparam int unsigned DEF_IMG_H     = 480;
   localparam int unsigned DEF_DW        = 16;
   localparam int unsigned DEF_NUM_BG    = 4;
   localparam int unsigned DEF_BG_STRIDE = 153601;
   localparam int unsigned DEF_SRAM_AW   = 20;
   localparam int unsigned DEF_OCM_AW    = 19;

   localparam logic [15:0] TERM_THRESH = 16'hF000;

   // Index width that stays at least one bit for degenerate counts.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bg_loader_dma_bg_addr_gen.sv
// Base latch, word counter and address generation for the background loader.
module bg_addr_gen
   import bg_loader_pkg::*;
#(
   parameter int unsigned WORDS     = 153600,
   parameter int unsigned NUM_BG    = DEF_NUM_BG,
   parameter int unsigned BG_STRIDE = DEF_BG_STRIDE,
   parameter int unsigned SRAM_AW   = DEF_SRAM_AW,
   parameter int unsigned OCM_AW    = DEF_OCM_AW,
   parameter int unsigned SW        = 2
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               load,
   input  logic [SW-1:0]      sel,
   input  logic               inc,
   output logic [SRAM_AW-1:0] sram_addr_c,
   output logic [OCM_AW-1:0]  ocm_addr_c,
   output logic               last_c,
   output logic               bad_sel_c
);

   localparam int unsigned CW = clog2_min1(WORDS);
   localparam int unsigned PW = SRAM_AW + 32;

   logic [SRAM_AW-1:0] base;
   logic [CW-1:0]      count;
   logic [PW-1:0]      prod;

   // Base is truncated to the SRAM address width.
   assign prod = PW'(sel) * PW'(BG_STRIDE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         base  <= '0;
         count <= '0;
      end else if (load) begin
         base  <= prod[SRAM_AW-1:0];
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   assign sram_addr_c = base + SRAM_AW'(count);
   assign ocm_addr_c  = OCM_AW'(count);
   assign last_c      = (count == CW'(WORDS - 1));
   assign bad_sel_c   = (32'(sel) >= NUM_BG);

endmodule

// File: rtl/bg_loader_dma.sv
// Background copy engine: streams one selected image from SRAM to the OCM framebuffer.
// Optional BG_LOADER_TERM_EN: a fetched word above TERM_THRESH ends the transfer early.
module bg_loader_dma
   import bg_loader_pkg::*;
#(
   parameter int unsigned IMG_W     = DEF_IMG_W,
   parameter int unsigned IMG_H     = DEF_IMG_H,
   parameter int unsigned DW        = DEF_DW,
   parameter int unsigned NUM_BG    = DEF_NUM_BG,
   parameter int unsigned BG_STRIDE = DEF_BG_STRIDE,
   parameter int unsigned SRAM_AW   = DEF_SRAM_AW,
   parameter int unsigned OCM_AW    = DEF_OCM_AW
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [clog2_min1(NUM_BG)-1:0] bg_sel,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic                          sram_rd,
   output logic [SRAM_AW-1:0]            sram_addr,
   input  logic                          sram_ack,
   input  logic [DW-1:0]                 sram_data,
   output logic                          ocm_we,
   input  logic                          ocm_ready,
   output logic [OCM_AW-1:0]             ocm_addr,
   output logic [DW-1:0]                 ocm_data
);

   localparam int unsigned WORDS = IMG_W * IMG_H / (DW / 8);
   localparam int unsigned SW    = clog2_min1(NUM_BG);

   state_t state, state_nxt;
   logic   err_q;
   logic   load_c, inc_c, last_c, bad_sel_c, term_hit_c;

   bg_addr_gen #(
      .WORDS     (WORDS),
      .NUM_BG    (NUM_BG),
      .BG_STRIDE (BG_STRIDE),
      .SRAM_AW   (SRAM_AW),
      .OCM_AW    (OCM_AW),
      .SW        (SW)
   ) u_addr (
      .Clk         (Clk),
      .Reset       (Reset),
      .load        (load_c),
      .sel         (bg_sel),
      .inc         (inc_c),
      .sram_addr_c (sram_addr),
      .ocm_addr_c  (ocm_addr),
      .last_c      (last_c),
      .bad_sel_c   (bad_sel_c)
   );

`ifdef BG_LOADER_TERM_EN
   assign term_hit_c = (16'(sram_data) > TERM_THRESH);
`else
   assign term_hit_c = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Captured word and error flag; an aborted ack is not captured.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ocm_data <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_IDLE && start)
            err_q <= bad_sel_c;
         if (state == ST_REQ && sram_ack && !abort)
            ocm_data <= sram_data;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = bad_sel_c ? ST_DONE : ST_REQ;
         ST_REQ: begin
            if (abort)         state_nxt = ST_IDLE;
            else if (sram_ack) state_nxt = term_hit_c ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            if (abort)          state_nxt = ST_IDLE;
            else if (ocm_ready) state_nxt = last_c ? ST_DONE : ST_REQ;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != ST_IDLE);
      sram_rd = (state == ST_REQ);
      ocm_we  = (state == ST_WRITE);
      done    = (state == ST_DONE);
      err     = (state == ST_DONE) && err_q;
      load_c  = (state == ST_IDLE) && start;
      inc_c   = (state == ST_WRITE) && ocm_ready && !abort && !last_c;
   end

endmodule
